// File: rtl/sr_readback_packer.sv
// ---------------------------------------------------------------------------
// sr_readback_packer
//
// Drains the 36-bit readback FIFO filled by the shift-register configuration
// block and frames each shift frame into a packet of 32-bit words on a
// valid/ready stream:
//   header  {8'hA5, seq, N, 8'h00}
//   N payload words (fifo_q[31:0]; zero-padded after a timeout)
//   trailer {8'h5A, seq, 14'h0, timeout, mismatch}  (only with the macro below)
//
// Optional feature macro: SR_PACKER_TRAILER_EN
//   defined   : trailer word present, m_last on the trailer
//   undefined : no trailer, m_last on the final payload word
//
// Ports:
//   clk         single clock (also the FIFO read clock)
//   rst_n       synchronous active-low reset
//   fifo_empty  readback FIFO empty flag
//   fifo_q      FIFO data: [31:0] payload, [35] last-word-of-frame flag
//   fifo_rd_en  FIFO pop strobe (one-cycle read latency assumed)
//   m_data      packet word
//   m_valid     m_data valid
//   m_ready     host accepts the word when m_valid && m_ready
//   m_last      final word of the packet
//   busy        high whenever the FSM is not idle
//   err_sticky  bit0 last-flag mismatch seen, bit1 timeout seen (sticky)
//   clr_err     one-cycle pulse clearing err_sticky
// ---------------------------------------------------------------------------
module sr_readback_packer #(
    parameter int WIDTH      = 50,
    parameter int FIFO_WIDTH = 36,
    parameter int SEQ_WIDTH  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_q,
    output logic                  fifo_rd_en,
    output logic [31:0]           m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [1:0]            err_sticky,
    input  logic                  clr_err
);

    localparam int N     = (WIDTH + 31) / 32;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [7:0]       N_BYTE   = 8'(N);
    localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        POP,
        CAPT,
        SEND,
        TRAIL
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SEQ_WIDTH-1:0] seq;
    logic [IDX_W-1:0]     idx;
    logic [7:0]           to_cnt;
    logic                 frame_to;
    logic                 frame_mm;
    logic [7:0]           seq_byte;
    logic                 last_word;
    logic                 pkt_done;
    logic                 unused_fifo_bits;

    assign seq_byte         = 8'(seq);
    assign last_word        = (idx == LAST_IDX);
    assign unused_fifo_bits = ^fifo_q[34:32];

    // The packet is complete when its final word is accepted: the trailer
    // when present, otherwise the last payload word.
`ifdef SR_PACKER_TRAILER_EN
    assign pkt_done = (state == TRAIL) && m_ready;
`else
    assign pkt_done = (state == SEND) && m_ready && last_word;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Frame boundaries come from the word counter only;
    // bit 35 of the FIFO word is checked but never used to resynchronise.
    // Once a timeout is flagged, POP goes straight to SEND with a padded word.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = HEAD;
                end
            end
            HEAD: begin
                if (m_ready) begin
                    state_nxt = POP;
                end
            end
            POP: begin
                if (frame_to) begin
                    state_nxt = SEND;
                end else if (!fifo_empty) begin
                    state_nxt = CAPT;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = SEND;
                end
            end
            CAPT: begin
                state_nxt = SEND;
            end
            SEND: begin
                if (m_ready) begin
                    if (last_word) begin
`ifdef SR_PACKER_TRAILER_EN
                        state_nxt = TRAIL;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        state_nxt = POP;
                    end
                end
            end
            TRAIL: begin
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state. The pop strobe also looks at fifo_empty so
    // it can never fire on an empty FIFO, and it is suppressed after a
    // timeout so the rest of the frame is padded without touching the FIFO.
    always_comb begin
        fifo_rd_en = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            POP: begin
                fifo_rd_en = !fifo_empty && !frame_to;
            end
            HEAD: begin
                m_valid = 1'b1;
            end
            SEND: begin
                m_valid = 1'b1;
`ifndef SR_PACKER_TRAILER_EN
                m_last  = last_word;
`endif
            end
            TRAIL: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
            end
            default: begin
                m_valid = 1'b0;
            end
        endcase
    end

    // Datapath: output word register, word index, timeout counter, per-frame
    // error bits, sequence number and sticky errors. m_data only changes in
    // states where m_valid is low or on the accepting edge, so it is stable
    // during stalls. A clr_err pulse on the packet-completing edge clears the
    // old sticky bits but keeps the bits this frame raises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data     <= '0;
            seq        <= '0;
            idx        <= '0;
            to_cnt     <= '0;
            frame_to   <= 1'b0;
            frame_mm   <= 1'b0;
            err_sticky <= '0;
        end else begin
            if (pkt_done) begin
                seq        <= seq + 1'b1;
                err_sticky <= (clr_err ? 2'b00 : err_sticky) | {frame_to, frame_mm};
            end else if (clr_err) begin
                err_sticky <= '0;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        m_data   <= {8'hA5, seq_byte, N_BYTE, 8'h00};
                        idx      <= '0;
                        to_cnt   <= '0;
                        frame_to <= 1'b0;
                        frame_mm <= 1'b0;
                    end
                end
                POP: begin
                    if (frame_to) begin
                        m_data <= '0;
                    end else if (!fifo_empty) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        frame_to <= 1'b1;
                        to_cnt   <= '0;
                        m_data   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                CAPT: begin
                    m_data <= fifo_q[31:0];
                    if (fifo_q[35] != last_word) begin
                        frame_mm <= 1'b1;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        idx <= idx + 1'b1;
`ifdef SR_PACKER_TRAILER_EN
                        if (last_word) begin
                            m_data <= {8'h5A, seq_byte, 14'h0, frame_to, frame_mm};
                        end
`endif
                    end
                end
                default: begin
                    idx <= idx;
                end
            endcase
        end
    end

endmodule
